// File: rtl/ex_advint_wb.sv
// ex_advint_wb: stages the MUL/DIV result pair and writes it to the register file through one port.
module ex_advint_wb #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6,
  parameter int SKIP_R0 = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_lo,
  input  logic [DATA_W-1:0] in_hi,
  input  logic [ADDR_W-1:0] in_rd1,
  input  logic [ADDR_W-1:0] in_rd2,
  input  logic              in_dual,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_grant,
  output logic              busy,
  output logic              hz_valid1,
  output logic [ADDR_W-1:0] hz_addr1,
  output logic              hz_valid2,
  output logic [ADDR_W-1:0] hz_addr2
);
  typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] lo_q, hi_q, lo_s, hi_s;
  logic [ADDR_W-1:0] rd1_q, rd2_q, rd1_s, rd2_s;
  logic need2_q, need1, need2, fin, cap;
  always_comb begin
    need1 = !(SKIP_R0 != 0 && in_rd1 == '0);
    need2 = in_dual && !(SKIP_R0 != 0 && in_rd2 == '0);
    fin = state == WR2 || (state == WR1 && !need2_q);
    in_ready = state == IDLE || (fin && rf_grant);
    cap = in_valid && in_ready;
    lo_s = cap ? in_lo : lo_q;
    hi_s = cap ? in_hi : hi_q;
    rd1_s = cap ? in_rd1 : rd1_q;
    rd2_s = cap ? in_rd2 : rd2_q;
    state_nxt = state;
    if (cap)
      state_nxt = need1 ? WR1 : need2 ? WR2 : IDLE;
    else if (state == WR1 && rf_grant)
      state_nxt = need2_q ? WR2 : IDLE;
    else if (state == WR2 && rf_grant)
      state_nxt = IDLE;
  end
  // Write-port outputs are registered from the next state, so they appear the cycle after capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lo_q <= '0;
      hi_q <= '0;
      rd1_q <= '0;
      rd2_q <= '0;
      need2_q <= 1'b0;
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (cap) begin
        lo_q <= in_lo;
        hi_q <= in_hi;
        rd1_q <= in_rd1;
        rd2_q <= in_rd2;
        need2_q <= need2;
      end
      rf_we <= state_nxt != IDLE;
      rf_waddr <= state_nxt == WR1 ? rd1_s : state_nxt == WR2 ? rd2_s : rf_waddr;
      rf_wdata <= state_nxt == WR1 ? lo_s : state_nxt == WR2 ? hi_s : rf_wdata;
    end
  end
  assign busy = state != IDLE;
  assign hz_valid1 = state == WR1;
  assign hz_valid2 = need2_q && state != IDLE;
  assign hz_addr1 = rd1_q;
  assign hz_addr2 = rd2_q;
endmodule

// File: tb/tb_ex_advint_wb.sv
// tb_ex_advint_wb: directed and random checks of ex_advint_wb against a write-list scoreboard.
module tb_ex_advint_wb;
  localparam int DW = 64;
  localparam int AW = 6;
  localparam int SKIP = 1;
  logic clk, rst_n, in_valid, in_ready, in_dual, rf_we, rf_grant, busy, hz_valid1, hz_valid2;
  logic [DW-1:0] in_lo, in_hi, rf_wdata;
  logic [AW-1:0] in_rd1, in_rd2, rf_waddr, hz_addr1, hz_addr2;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] e;
  int n_chk = 0;
  int n_fail = 0;
  ex_advint_wb #(.DATA_W(DW), .ADDR_W(AW), .SKIP_R0(SKIP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_lo(in_lo), .in_hi(in_hi), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_dual(in_dual),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_grant(rf_grant),
    .busy(busy), .hz_valid1(hz_valid1), .hz_addr1(hz_addr1),
    .hz_valid2(hz_valid2), .hz_addr2(hz_addr2)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Reference model: every accepted result expands into its list of architectural writes.
  always @(negedge clk) begin
    if (!rst_n) exp_q.delete();
    else if (in_valid && in_ready) begin
      if (!SKIP || in_rd1 != 0) exp_q.push_back({in_rd1, in_lo});
      if (in_dual && (!SKIP || in_rd2 != 0)) exp_q.push_back({in_rd2, in_hi});
    end
  end
  always @(negedge clk) begin
    if (rst_n && rf_we && rf_grant) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("sb_addr", DW'(rf_waddr), DW'(e[AW+DW-1:DW]));
        chk("sb_data", rf_wdata, e[DW-1:0]);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic d);
    in_valid = 1; in_lo = lo; in_hi = hi; in_rd1 = r1; in_rd2 = r2; in_dual = d;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rst_n = 0; in_valid = 0; in_lo = 0; in_hi = 0; in_rd1 = 0; in_rd2 = 0; in_dual = 0; rf_grant = 0;
    repeat (2) step();
    chk("rst_ready", in_ready, 1); chk("rst_we", rf_we, 0); chk("rst_busy", busy, 0);
    chk("rst_hz1", hz_valid1, 0); chk("rst_hz2", hz_valid2, 0); chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0); chk("rst_hzaddr", {hz_addr1, hz_addr2}, 0);
    rst_n = 1;
    step();
    // single MUL
    rf_grant = 1;
    send(64'h1, '1, 5, 6, 1);
    step(); in_valid = 0;
    chk("mul_we1", rf_we, 1); chk("mul_a1", rf_waddr, 5); chk("mul_d1", rf_wdata, 1);
    chk("mul_rdy1", in_ready, 0); chk("mul_busy", busy, 1);
    step();
    chk("mul_we2", rf_we, 1); chk("mul_a2", rf_waddr, 6); chk("mul_d2", rf_wdata, '1);
    chk("mul_rdy2", in_ready, 1);
    step();
    chk("mul_we3", rf_we, 0); chk("mul_rdy3", in_ready, 1);
    // grant stall
    rf_grant = 0;
    send(64'h1, '1, 5, 6, 1);
    step(); in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rf_grant = 1;
      chk("stall_a", rf_waddr, 5); chk("stall_d", rf_wdata, 1); chk("stall_we", rf_we, 1);
      chk("stall_hz1", hz_valid1, 1); chk("stall_hz2", hz_valid2, 1);
      chk("stall_hza", {hz_addr1, hz_addr2}, {6'd5, 6'd6});
      step();
    end
    chk("stall_hz1_off", hz_valid1, 0); chk("stall_hz2_on", hz_valid2, 1);
    chk("stall_a2", rf_waddr, 6); chk("stall_d2", rf_wdata, '1);
    step();
    chk("stall_done", rf_we, 0); chk("stall_hz2_off", hz_valid2, 0);
    // r0 suppression
    send(64'h11, 64'h77, 0, 7, 1);
    step(); in_valid = 0;
    chk("r0_we", rf_we, 1); chk("r0_a", rf_waddr, 7); chk("r0_d", rf_wdata, 64'h77);
    chk("r0_hz1", hz_valid1, 0); chk("r0_hz2", hz_valid2, 1);
    step();
    chk("r0_idle", rf_we, 0);
    send(64'h22, 64'h33, 0, 3, 0);
    step(); in_valid = 0;
    chk("r0_none_we", rf_we, 0); chk("r0_none_rdy", in_ready, 1); chk("r0_none_busy", busy, 0);
    // back-to-back
    send(64'hA1, 64'hA2, 10, 11, 1);
    step();
    send(64'hB1, 64'hB2, 12, 13, 1);
    chk("b2b_a1", rf_waddr, 10); chk("b2b_d1", rf_wdata, 64'hA1);
    step();
    chk("b2b_a2", rf_waddr, 11); chk("b2b_d2", rf_wdata, 64'hA2); chk("b2b_rdy", in_ready, 1);
    step(); in_valid = 0;
    chk("b2b_we3", rf_we, 1); chk("b2b_a3", rf_waddr, 12); chk("b2b_d3", rf_wdata, 64'hB1);
    step();
    chk("b2b_we4", rf_we, 1); chk("b2b_a4", rf_waddr, 13); chk("b2b_d4", rf_wdata, 64'hB2);
    step();
    chk("b2b_end", rf_we, 0);
    // same destination
    send(64'hA, 64'hB, 9, 9, 1);
    step(); in_valid = 0;
    chk("same_a1", rf_waddr, 9); chk("same_d1", rf_wdata, 64'hA); chk("same_hz2a", hz_valid2, 1);
    step();
    chk("same_a2", rf_waddr, 9); chk("same_d2", rf_wdata, 64'hB); chk("same_hz2b", hz_valid2, 1);
    chk("same_hz1", hz_valid1, 0);
    step();
    chk("same_hz2_off", hz_valid2, 0);
    // async reset mid-WR1
    rf_grant = 0;
    send(64'h5, 64'h6, 20, 21, 1);
    step(); in_valid = 0;
    chk("ar_we_pre", rf_we, 1);
    #2 rst_n = 0;
    #1;
    chk("ar_we", rf_we, 0); chk("ar_busy", busy, 0);
    chk("ar_hz", {hz_valid1, hz_valid2}, 0);
    @(negedge clk);
    #1 rst_n = 1; rf_grant = 1;
    chk("ar_rdy", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_nowrite", rf_we, 0);
    end
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid = $urandom_range(0, 9) < 6;
      in_lo = {$urandom, $urandom};
      in_hi = {$urandom, $urandom};
      in_rd1 = AW'($urandom_range(0, 7));
      in_rd2 = AW'($urandom_range(0, 7));
      in_dual = $urandom_range(0, 1) == 1;
      rf_grant = $urandom_range(0, 3) != 0;
      step();
    end
    in_valid = 0; rf_grant = 1;
    for (int i = 0; i < 20 && busy; i++) step();
    step();
    chk("drain_busy", busy, 0);
    chk("drain_queue", DW'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
